// File: rtl/modred_rr_arbiter_if.sv
// Request/response bundle between the butterfly lanes, the arbiter and the
// shared Barrett reduction unit. The arbiter side uses the slave modport.
interface modred_rr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 16
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [DATA_SIZE-1:0]         red_x;
  logic [DATA_SIZE/2-1:0]       red_result;
  logic                         rsp_valid;
  logic [ID_W-1:0]              rsp_id;
  logic [DATA_SIZE/2-1:0]       rsp_data;

  modport master (
    output req_valid, req_data, red_result,
    input  req_ready, red_x, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, red_result,
    output req_ready, red_x, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/modred_rr_arbiter.sv
// Round-robin arbiter sharing one fixed-latency reduction unit among NUM_REQ
// requesters. Define MODRED_ARB_STATS_EN to add grant/conflict counters.
module modred_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_SIZE   = 16,
  parameter int RED_LATENCY = 2,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  modred_rr_arbiter_if.slave   bus,
`ifdef MODRED_ARB_STATS_EN
  output logic [31:0]          grant_cnt,
  output logic [31:0]          conflict_cnt,
`endif
  output logic                 busy
);

  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        grant_id;
  logic [ID_W:0]          cand;
  logic                   found;
  logic                   transfer;
  logic [RED_LATENCY-1:0] tag_valid;
  logic [ID_W-1:0]        tag_id [RED_LATENCY];

  // Scan from rr_ptr with a manual wrap so non-power-of-two NUM_REQ works.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!found && bus.req_valid[cand[ID_W-1:0]]) begin
        found    = 1'b1;
        grant_id = cand[ID_W-1:0];
      end
    end
  end

  assign transfer      = found & en & ~rst;
  assign bus.req_ready = transfer ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.red_x     = transfer ? bus.req_data[grant_id*DATA_SIZE +: DATA_SIZE] : '0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (rst) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
  end

  // Tag pipeline mirrors the unit's latency and never stalls.
  always_ff @(posedge clk) begin
    // NOTE: the ids are cleared too, not just the valids, so rsp_id reads 0 after reset.
    if (rst) begin
      tag_valid <= '0;
      for (int s = 0; s < RED_LATENCY; s++) tag_id[s] <= '0;
    end else begin
      tag_valid[0] <= transfer;
      tag_id[0]    <= grant_id;
      for (int s = 1; s < RED_LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
    end
  end

  assign bus.rsp_valid = tag_valid[RED_LATENCY-1];
  assign bus.rsp_id    = tag_id[RED_LATENCY-1];
  assign bus.rsp_data  = bus.rsp_valid ? bus.red_result : '0;
  assign busy          = |tag_valid;

`ifdef MODRED_ARB_STATS_EN
  logic multi_req;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_req = |(bus.req_valid & (bus.req_valid - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (transfer && grant_cnt != '1) grant_cnt <= grant_cnt + 1'b1;
      if (en && multi_req && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule
